// File: rtl/sync_call_initiator.sv
// Initiator end of the sync valid/ready call protocol.
// Issues one operand pair to a compute target, waits (under a watchdog) for
// the target's result, and returns it upstream together with a latency count.
// Exactly one call is in flight at a time; every output comes straight from a flop.
module sync_call_initiator #(
  parameter int intN    = 8,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [intN-1:0] req_a,
  input  logic [intN-1:0] req_b,
  output logic            dut_in_valid,
  input  logic            dut_in_ready,
  output logic [intN-1:0] dut_in0,
  output logic [intN-1:0] dut_in1,
  input  logic            dut_out_valid,
  output logic            dut_out_ready,
  input  logic [intN-1:0] dut_out0,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [intN-1:0] rsp_data,
  output logic            rsp_timeout,
  output logic [CW-1:0]   rsp_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            req_ready_q, req_ready_d;
  logic            in_valid_q, in_valid_d;
  logic            out_ready_q, out_ready_d;
  logic [intN-1:0] in0_q, in0_d;
  logic [intN-1:0] in1_q, in1_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [intN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]   rsp_cycles_q, rsp_cycles_d;

  // Saturating increment of the WAIT-cycle counter; it is also the count
  // reported for the cycle on which the result is captured.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Next-state and next-output decode for the call sequence.
  always_comb begin
    // NOTE: every *_d gets a hold value first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready_q;
    in_valid_d    = in_valid_q;
    out_ready_d   = out_ready_q;
    in0_d         = in0_q;
    in1_d         = in1_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_cycles_d  = rsp_cycles_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          in0_d       = req_a;
          in1_d       = req_b;
          req_ready_d = 1'b0;
          in_valid_d  = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // in_valid stays up until the target takes the operands; no watchdog here.
        if (dut_in_ready) begin
          in_valid_d  = 1'b0;
          out_ready_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // A result arriving on the final watchdog cycle still wins.
        if (dut_out_valid) begin
          rsp_data_d    = dut_out0;
          rsp_cycles_d  = cnt_inc;
          rsp_timeout_d = 1'b0;
          out_ready_d   = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (cnt_inc == TIMEOUT_C) begin
          rsp_data_d    = '0;
          rsp_cycles_d  = TIMEOUT_C;
          rsp_timeout_d = 1'b1;
          out_ready_d   = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        in_valid_d  = 1'b0;
        out_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any call in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!nrst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      in_valid_q    <= 1'b0;
      out_ready_q   <= 1'b0;
      in0_q         <= '0;
      in1_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_cycles_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      in_valid_q    <= in_valid_d;
      out_ready_q   <= out_ready_d;
      in0_q         <= in0_d;
      in1_q         <= in1_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_cycles_q  <= rsp_cycles_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign dut_in_valid  = in_valid_q;
  assign dut_out_ready = out_ready_q;
  assign dut_in0       = in0_q;
  assign dut_in1       = in1_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign rsp_cycles    = rsp_cycles_q;

endmodule

// File: tb/tb_sync_call_initiator.sv
// Bench for sync_call_initiator: the bench itself plays the compute target,
// with a behavioural gcd and a call-level expectation model.
module tb_sync_call_initiator;

  localparam int W  = 8;
  localparam int TO = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a, req_b;
  logic          dut_in_valid;
  logic          dut_in_ready;
  logic [W-1:0]  dut_in0, dut_in1;
  logic          dut_out_valid;
  logic          dut_out_ready;
  logic [W-1:0]  dut_out0;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_timeout;
  logic [CW-1:0] rsp_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int in_hs    = 0;
  int rsp_hs   = 0;

  sync_call_initiator #(.intN(W), .TIMEOUT(TO), .CW(CW)) u_dut (
    .clk          (clk),
    .nrst         (nrst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .dut_in_valid (dut_in_valid),
    .dut_in_ready (dut_in_ready),
    .dut_in0      (dut_in0),
    .dut_in1      (dut_in1),
    .dut_out_valid(dut_out_valid),
    .dut_out_ready(dut_out_ready),
    .dut_out0     (dut_out0),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_timeout  (rsp_timeout),
    .rsp_cycles   (rsp_cycles)
  );

  always #5 clk = ~clk;

  // Handshake monitors: count target-input and upstream-response transfers.
  always @(posedge clk) begin
    if (nrst && dut_in_valid && dut_in_ready) in_hs <= in_hs + 1;
    if (nrst && rsp_valid && rsp_ready) rsp_hs <= rsp_hs + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int x = a;
    int y = b;
    while (y != 0) begin
      int t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   req_ready,     1);
    check({tag, "_in_valid"},    dut_in_valid,  0);
    check({tag, "_out_ready"},   dut_out_ready, 0);
    check({tag, "_rsp_valid"},   rsp_valid,     0);
    check({tag, "_rsp_timeout"}, rsp_timeout,   0);
    check({tag, "_rsp_data"},    rsp_data,      0);
    check({tag, "_rsp_cycles"},  rsp_cycles,    0);
    check({tag, "_in0"},         dut_in0,       0);
    check({tag, "_in1"},         dut_in1,       0);
  endtask

  // One complete call. lat = WAIT cycle (1-based) on which the target raises
  // out_valid with out0=d; lat > TO means the target never answers in time.
  task automatic do_call(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] d,
                         input int in_delay, input int lat, input int bp);
    int   hs0, rhs0, k;
    logic exp_to;
    int   exp_d, exp_c;
    exp_to = (lat > TO);
    exp_d  = exp_to ? 0 : int'(d);
    exp_c  = exp_to ? TO : lat;
    hs0    = in_hs;
    rhs0   = rsp_hs;

    check("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_a = a; req_b = b;
    step();
    req_valid = 1'b0; req_a = W'($urandom); req_b = W'($urandom);
    check("issue_in_valid", dut_in_valid, 1);
    check("issue_in0", dut_in0, a);
    check("issue_in1", dut_in1, b);
    check("issue_req_ready", req_ready, 0);
    check("issue_out_ready", dut_out_ready, 0);

    repeat (in_delay) begin
      step();
      check("stall_in_valid", dut_in_valid, 1);
      check("stall_in0", dut_in0, a);
      check("stall_in1", dut_in1, b);
    end
    dut_in_ready = 1'b1;
    step();
    dut_in_ready = 1'b0;
    check("wait_in_valid", dut_in_valid, 0);
    check("wait_out_ready", dut_out_ready, 1);
    check("in_handshakes", in_hs - hs0, 1);

    k = 0;
    while (k < TO + 3) begin
      k++;
      dut_out_valid = (k == lat);
      dut_out0      = (k == lat) ? d : W'($urandom);
      step();
      dut_out_valid = 1'b0;
      if (rsp_valid) break;
    end
    check("wait_cycles_to_rsp", k, exp_c);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, exp_d);
    check("rsp_timeout", rsp_timeout, exp_to);
    check("rsp_cycles", rsp_cycles, exp_c);
    check("resp_out_ready", dut_out_ready, 0);

    // Back-pressure with a stray out_valid pulse that must be ignored.
    repeat (bp) begin
      dut_out_valid = 1'b1; dut_out0 = 8'hA5;
      step();
      dut_out_valid = 1'b0;
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, exp_d);
      check("bp_rsp_cycles", rsp_cycles, exp_c);
      check("bp_rsp_timeout", rsp_timeout, exp_to);
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_req_ready", req_ready, 1);
    check("done_in_handshakes", in_hs - hs0, 1);
    check("done_rsp_handshakes", rsp_hs - rhs0, 1);
  endtask

  initial begin
    nrst = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0;
    dut_in_ready = 1'b0; dut_out_valid = 1'b0; dut_out0 = '0; rsp_ready = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    nrst = 1'b1;
    step();
    check_reset_outputs("idle_after_reset");

    // Directed gcd call, target answers 3 cycles after the input handshake.
    do_call(8'd21, 8'd35, gcd(8'd21, 8'd35), 0, 3, 0);
    // Target stalls the input handshake for 5 cycles.
    do_call(8'd21, 8'd35, gcd(8'd21, 8'd35), 5, 1, 0);
    // Target never answers: timeout, stray out_valid ignored, next call works.
    do_call(8'd5, 8'd10, 8'd5, 0, 1000, 2);
    do_call(8'd12, 8'd18, gcd(8'd12, 8'd18), 0, 2, 0);
    // Upstream back-pressure for 7 cycles, then immediate next request.
    do_call(8'd100, 8'd75, gcd(8'd100, 8'd75), 1, 4, 7);
    do_call(8'd9, 8'd6, gcd(8'd9, 8'd6), 0, 1, 0);
    // Result arrives on the very cycle the watchdog would fire.
    do_call(8'd40, 8'd60, 8'd9, 0, TO, 0);

    // Reset in the middle of WAIT abandons the call.
    req_valid = 1'b1; req_a = 8'd99; req_b = 8'd33;
    step();
    req_valid = 1'b0; dut_in_ready = 1'b1;
    step();
    dut_in_ready = 1'b0;
    step();
    step();
    check("midwait_out_ready", dut_out_ready, 1);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    check_reset_outputs("midwait_reset");
    step();
    check("post_reset_rsp_valid", rsp_valid, 0);
    do_call(8'd48, 8'd18, gcd(8'd48, 8'd18), 0, 2, 0);

    // Randomized calls against the call-level model.
    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(1, 255));
      b = W'($urandom_range(1, 255));
      do_call(a, b, gcd(a, b), $urandom_range(0, 3), $urandom_range(1, TO + 3),
              $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
